// File: rtl/sha256_iter_core.sv
// sha256_iter_core
// Iterative SHA-256 compression engine with a start/busy/done handshake.
// One 512-bit block is compressed against a 256-bit chaining value, either the
// caller's midstate or the standard IV. UNROLL rounds are computed per clock,
// so a compression takes RC = 64/UNROLL cycles.
//
// Optional build macro: SHA256_DOUBLE_EN
//   When defined, the first digest is padded into a second block and hashed
//   again from the standard IV (SHA-256d). done_o then fires once, at the end
//   of the second compression. When undefined, only a single compression is
//   performed.
//
// Ports
//   clk       in   1    clock, all logic on posedge
//   rst       in   1    synchronous reset, active-high
//   start_i   in   1    request, accepted only while idle
//   use_iv_i  in   1    1: standard IV, 0: chain_i (sampled at accept)
//   chain_i   in   256  chaining value, [255:224]=H0 .. [31:0]=H7
//   blk_i     in   512  message block, [511:480]=W0 .. [31:0]=W15
//   busy_o    out  1    high from the cycle after accept until done_o
//   done_o    out  1    one-cycle pulse, digest_o valid in that cycle
//   digest_o  out  256  result, [255:224]=H0 .. [31:0]=H7, held until next done
//
// UNROLL must be 1, 2, 4 or 8.
`timescale 1ns/1ps
module sha256_iter_core #(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic         use_iv_i,
  input  logic [255:0] chain_i,
  input  logic [511:0] blk_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [255:0] digest_o
);

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Round index of the last step of a compression; the counter wraps to 0 after it.
  localparam logic [5:0] LAST_RND = 6'(64 - UNROLL);

`ifdef SHA256_DOUBLE_EN
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_FIN  = 3'd2,
    ST_RUN2 = 3'd3,
    ST_FIN2 = 3'd4
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;
`endif

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_s0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_s1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] sml_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sml_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // One compression round on the packed working state {a,b,c,d,e,f,g,h}.
  function automatic logic [255:0] sha_round(input logic [255:0] s, input logic [31:0] w,
                                             input logic [31:0] k);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + big_s1(e) + ((e & f) ^ (~e & g)) + k + w;
    t2 = big_s0(a) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  // Slide the 16-word schedule window by one word; the head is always W[t].
  function automatic logic [511:0] sched_step(input logic [511:0] w);
    logic [31:0] w_new;
    w_new = sml_s1(w[63:32]) + w[223:192] + sml_s0(w[479:448]) + w[511:480];
    return {w[479:0], w_new};
  endfunction

  // Word-wise modulo-2^32 addition of two 8-word hash values.
  function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    r = 256'h0;
    for (int i = 0; i < 8; i++) begin
      r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
    end
    return r;
  endfunction

  state_e       state_q;
  logic [5:0]   rnd_q;
  logic [255:0] st_q;
  logic [255:0] chain_q;
  logic [511:0] w_q;
  logic         busy_q;
  logic         done_q;
  logic [255:0] digest_q;

  logic [255:0] st_d;
  logic [511:0] w_d;
  logic [255:0] sum_d;
  logic         last_rnd_s;

  // Unrolled round datapath: UNROLL rounds from the current state and window.
  always_comb begin
    st_d = st_q;
    w_d  = w_q;
    for (int u = 0; u < UNROLL; u++) begin
      st_d = sha_round(st_d, w_d[511:480], K_ROM[rnd_q + 6'(u)]);
      w_d  = sched_step(w_d);
    end
    sum_d      = add8(chain_q, st_d);
    last_rnd_s = (rnd_q == LAST_RND);
  end

  // Control FSM, working registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rnd_q    <= 6'd0;
      st_q     <= 256'h0;
      chain_q  <= 256'h0;
      w_q      <= 512'h0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      digest_q <= 256'h0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            w_q     <= blk_i;
            chain_q <= use_iv_i ? IV : chain_i;
            st_q    <= use_iv_i ? IV : chain_i;
            rnd_q   <= 6'd0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          st_q  <= st_d;
          w_q   <= w_d;
          rnd_q <= rnd_q + 6'(UNROLL);
          if (last_rnd_s) begin
`ifdef SHA256_DOUBLE_EN
            // First digest parks in chain_q until FIN builds the second block.
            chain_q <= sum_d;
`else
            digest_q <= sum_d;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
`endif
            state_q <= ST_FIN;
          end
        end
`ifdef SHA256_DOUBLE_EN
        ST_FIN: begin
          // Second block: 256-bit digest, pad bit, zeros, 256-bit length.
          w_q     <= {chain_q, 32'h80000000, 160'h0, 64'h100};
          st_q    <= IV;
          chain_q <= IV;
          rnd_q   <= 6'd0;
          state_q <= ST_RUN2;
        end
        ST_RUN2: begin
          st_q  <= st_d;
          w_q   <= w_d;
          rnd_q <= rnd_q + 6'(UNROLL);
          if (last_rnd_s) begin
            digest_q <= sum_d;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= ST_FIN2;
          end
        end
        ST_FIN2: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
`else
        ST_FIN: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
`endif
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign digest_o = digest_q;

endmodule

// File: tb/tb_sha256_iter_core.sv
`timescale 1ns/1ps
module tb_sha256_iter_core;

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_TAIL  = {32'h80000000, 448'h0, 32'h00000200};
  localparam logic [255:0] DIG_ABC1  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_ABC2  = 256'h4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358;
  localparam logic [255:0] DIG_EMP1  = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

`ifdef SHA256_DOUBLE_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start1, start4, use_iv;
  logic [255:0] chain;
  logic [511:0] blk;
  logic         busy1, done1, busy4, done4;
  logic [255:0] dig1, dig4;
  int           sel = 1;
  logic         busy_s, done_s;
  logic [255:0] dig_s;
  int           n_chk = 0;
  int           n_bad = 0;

  always #5 clk = ~clk;

  sha256_iter_core #(.UNROLL(1)) u_dut1 (
    .clk(clk), .rst(rst), .start_i(start1), .use_iv_i(use_iv), .chain_i(chain),
    .blk_i(blk), .busy_o(busy1), .done_o(done1), .digest_o(dig1)
  );

  sha256_iter_core #(.UNROLL(4)) u_dut4 (
    .clk(clk), .rst(rst), .start_i(start4), .use_iv_i(use_iv), .chain_i(chain),
    .blk_i(blk), .busy_o(busy4), .done_o(done4), .digest_o(dig4)
  );

  assign busy_s = (sel == 4) ? busy4 : busy1;
  assign done_s = (sel == 4) ? done4 : done1;
  assign dig_s  = (sel == 4) ? dig4  : dig1;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (FIPS 180-4, full 64-word schedule) ----
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    logic [63:0] xx;
    xx = {x, x} >> n;
    return xx[31:0];
  endfunction

  function automatic logic [255:0] ref_compress(input logic [255:0] hin, input logic [511:0] m);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] hh [8];
    logic [31:0] t1, t2, s0, s1;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) w[i] = m[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = s1 + w[i-7] + s0 + w[i-16];
    end
    for (int i = 0; i < 8; i++) begin
      hh[i] = hin[255 - 32*i -: 32];
      v[i]  = hh[i];
    end
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
           + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
      t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
           + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    r = 256'h0;
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hh[i] + v[i];
    return r;
  endfunction

  function automatic logic [255:0] ref_hash(input logic iv, input logic [255:0] ch, input logic [511:0] b);
    logic [255:0] d1;
    d1 = ref_compress(iv ? IV : ch, b);
    if (DBL) return ref_compress(IV, {d1, 32'h80000000, 160'h0, 64'h100});
    else     return d1;
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // One transaction; input ports are scrambled after accept, optional extra start pulses.
  task automatic run_txn(input string tag, input int u, input logic iv, input logic [255:0] ch,
                         input logic [511:0] b, input logic [255:0] exp,
                         input int junk_at, input bit poke_done);
    int lat, done_at, n_done, n_busy;
    logic [255:0] held;
    lat     = DBL ? 2 * (64 / u + 1) : (64 / u + 1);
    done_at = -1;
    n_done  = 0;
    n_busy  = 0;
    held    = 256'h0;
    sel     = u;
    @(negedge clk);
    use_iv = iv; chain = ch; blk = b;
    if (u == 1) start1 = 1'b1; else start4 = 1'b1;
    for (int n = 1; n <= lat + 4; n++) begin
      @(negedge clk);
      start1 = 1'b0; start4 = 1'b0;
      use_iv = 1'($urandom); chain = rnd512()[255:0]; blk = rnd512();
      if (busy_s) n_busy++;
      if (done_s) begin
        n_done++;
        if (done_at < 0) begin
          done_at = n;
          held    = dig_s;
          check_eq({tag, "_digest"}, dig_s, exp);
        end
        if (poke_done) begin
          if (u == 1) start1 = 1'b1; else start4 = 1'b1;
        end
      end
      if (n == junk_at) begin
        if (u == 1) start1 = 1'b1; else start4 = 1'b1;
      end
    end
    @(negedge clk);
    start1 = 1'b0; start4 = 1'b0;
    check_eq({tag, "_latency"}, 256'(done_at), 256'(lat));
    check_eq({tag, "_ndone"}, 256'(n_done), 256'd1);
    check_eq({tag, "_busycyc"}, 256'(n_busy), 256'(lat - 1));
    check_eq({tag, "_busyend"}, 256'(busy_s), 256'd0);
    check_eq({tag, "_held"}, dig_s, held);
  endtask

  initial begin
    logic [255:0] exp_v, ch_v;
    logic [511:0] b_v;
    logic         iv_v;
    int           n_done;
    rst = 1'b1; start1 = 1'b0; start4 = 1'b0; use_iv = 1'b0; chain = 256'h0; blk = 512'h0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy1", 256'(busy1), 256'd0);
    check_eq("rst_done1", 256'(done1), 256'd0);
    check_eq("rst_dig1", dig1, 256'h0);
    check_eq("rst_busy4", 256'(busy4), 256'd0);
    check_eq("rst_done4", 256'(done4), 256'd0);
    check_eq("rst_dig4", dig4, 256'h0);
    rst = 1'b0;
    @(negedge clk);

    // "abc", UNROLL=1, with ignored start pulses mid-run and at done
    run_txn("abc_u1", 1, 1'b1, 256'h0, BLK_ABC, DBL ? DIG_ABC2 : DIG_ABC1, 10, 1'b1);
    // empty message, UNROLL=4
    run_txn("empty_u4", 4, 1'b1, 256'h0, BLK_EMPTY,
            DBL ? ref_hash(1'b1, 256'h0, BLK_EMPTY) : DIG_EMP1, -1, 1'b0);
    // "abc" on the unrolled engine too
    run_txn("abc_u4", 4, 1'b1, 256'h0, BLK_ABC, DBL ? DIG_ABC2 : DIG_ABC1, 3, 1'b1);
    // midstate chaining
    run_txn("chain_u1", 1, 1'b0, DIG_ABC1, BLK_TAIL, ref_hash(1'b0, DIG_ABC1, BLK_TAIL), -1, 1'b0);
    run_txn("chain_u4", 4, 1'b0, DIG_ABC1, BLK_TAIL, ref_hash(1'b0, DIG_ABC1, BLK_TAIL), 5, 1'b0);

    // reset mid-operation: no done, outputs cleared next cycle
    sel = 1;
    n_done = 0;
    @(negedge clk);
    use_iv = 1'b1; blk = BLK_ABC; start1 = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (done1) n_done++;
    end
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_busy", 256'(busy1), 256'd0);
    check_eq("midrst_done", 256'(done1), 256'd0);
    check_eq("midrst_dig", dig1, 256'h0);
    rst = 1'b0;
    for (int n = 0; n < 70; n++) begin
      @(negedge clk);
      if (done1) n_done++;
    end
    check_eq("midrst_nodone", 256'(n_done), 256'd0);
    run_txn("abc_after_rst", 1, 1'b1, 256'h0, BLK_ABC, DBL ? DIG_ABC2 : DIG_ABC1, -1, 1'b0);

    // randomized blocks and chaining values against the model
    for (int i = 0; i < 8; i++) begin
      iv_v  = 1'($urandom);
      ch_v  = rnd512()[255:0];
      b_v   = rnd512();
      exp_v = ref_hash(iv_v, ch_v, b_v);
      run_txn($sformatf("rand%0d", i), (i % 2 == 0) ? 4 : 1, iv_v, ch_v, b_v, exp_v,
              int'($urandom_range(1, 12)), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
